pcg2_bounded_sampler: RTL and testbench



---
 rtl/pcg2_bounded_sampler_if.sv | 28 ++
 rtl/pcg2_bounded_sampler.sv | 136 +++++++++++++
 tb/tb_pcg2_bounded_sampler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pcg2_bounded_sampler_if.sv
// Request/result/random-feed bundle between a client, pcg2 and the bounded sampler.
interface pcg2_bounded_sampler_if #(
  parameter int BOUND_W = 32,
  parameter int TRY_W   = 8
);
  logic [63:0]        rand_in;
  logic               rand_valid;
  logic               req_valid;
  logic               req_ready;
  logic [BOUND_W-1:0] req_bound;
  logic               out_valid;
  logic               out_ready;
  logic [BOUND_W-1:0] out_value;
  logic               out_err;
  logic [TRY_W-1:0]   out_tries;

  // Sampler side
  modport slave (
    input  rand_in, rand_valid, req_valid, req_bound, out_ready,
    output req_ready, out_valid, out_value, out_err, out_tries
  );

  // Client / PRNG side
  modport master (
    output rand_in, rand_valid, req_valid, req_bound, out_ready,
    input  req_ready, out_valid, out_value, out_err, out_tries
  );
endinterface

// File: rtl/pcg2_bounded_sampler.sv
// Unbiased integer sampler in [0, bound): masks each 32-bit half of a pcg2 word
// down to the smallest power-of-two range covering bound-1 and rejects
// candidates >= bound, giving up after MAX_TRIES words.
module pcg2_bounded_sampler #(
  parameter int BOUND_W   = 32,
  parameter int MAX_TRIES = 16,
  parameter int TRY_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pcg2_bounded_sampler_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [BOUND_W-1:0] bound_q, bound_d;
  logic [BOUND_W-1:0] mask_q, mask_d;
  logic [TRY_W-1:0]   tries_q, tries_d;
  logic               out_valid_q, out_valid_d;
  logic [BOUND_W-1:0] out_value_q, out_value_d;
  logic               out_err_q, out_err_d;
  logic [TRY_W-1:0]   out_tries_q, out_tries_d;

  logic [BOUND_W-1:0] bound_m1, req_mask;
  logic [BOUND_W-1:0] c0, c1;
  logic [TRY_W-1:0]   tries_nxt;

  // Mask = bound-1 smeared rightward: every bit at or below its MSB set.
  // bound==0 yields garbage here but that request never samples.
  always_comb begin
    bound_m1 = bus.req_bound - BOUND_W'(1);
    req_mask = '0;
    for (int i = 0; i < BOUND_W; i++) req_mask[i] = |(bound_m1 >> i);
  end

  // Two candidates per word, one from each 32-bit half.
  always_comb begin
    c0        = bus.rand_in[BOUND_W-1:0] & mask_q;
    c1        = bus.rand_in[32+BOUND_W-1:32] & mask_q;
    tries_nxt = tries_q + TRY_W'(1);
  end

  // Next-state and result logic; everything holds unless a transition fires.
  always_comb begin
    state_d     = state_q;
    bound_d     = bound_q;
    mask_d      = mask_q;
    tries_d     = tries_q;
    out_valid_d = out_valid_q;
    out_value_d = out_value_q;
    out_err_d   = out_err_q;
    out_tries_d = out_tries_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          bound_d = bus.req_bound;
          mask_d  = req_mask;
          tries_d = '0;
          if (bus.req_bound == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_value_d = '0;
            out_tries_d = '0;
          end else begin
            state_d = SAMPLE;
          end
        end
      end
      SAMPLE: begin
        if (bus.rand_valid) begin
          if (c0 < bound_q) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            out_value_d = c0;
            out_tries_d = tries_nxt;
          end else if (c1 < bound_q) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b0;
            out_value_d = c1;
            out_tries_d = tries_nxt;
          end else if (tries_nxt == TRY_W'(MAX_TRIES)) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_value_d = '0;
            out_tries_d = tries_nxt;
          end else begin
            tries_d = tries_nxt;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset abandons any request in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      bound_q     <= '0;
      mask_q      <= '0;
      tries_q     <= '0;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= 1'b0;
      out_tries_q <= '0;
    end else begin
      state_q     <= state_d;
      bound_q     <= bound_d;
      mask_q      <= mask_d;
      tries_q     <= tries_d;
      out_valid_q <= out_valid_d;
      out_value_q <= out_value_d;
      out_err_q   <= out_err_d;
      out_tries_q <= out_tries_d;
    end
  end

  // req_ready is gated by rst so it stays low for the whole reset pulse.
  assign bus.req_ready = (state_q == IDLE) && !rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
  assign bus.out_err   = out_err_q;
  assign bus.out_tries = out_tries_q;

endmodule

// File: tb/tb_pcg2_bounded_sampler.sv
// Scoreboard bench for pcg2_bounded_sampler (MAX_TRIES=4): the driver pushes the
// expected result per request, the monitor pops and checks it at the output.
module tb_pcg2_bounded_sampler;

  localparam int MT = 4;

  typedef struct {
    logic [31:0] v;
    logic        e;
    logic [7:0]  t;
    int          lat;
    int          hs;
  } exp_t;

  typedef struct {
    logic        v;
    logic [63:0] w;
  } feed_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  exp_t  sb[$];
  feed_t feed[$];

  pcg2_bounded_sampler_if #(.BOUND_W(32), .TRY_W(8)) bus ();

  pcg2_bounded_sampler #(.BOUND_W(32), .MAX_TRIES(MT), .TRY_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    feed.push_back('{1'b1, w});
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) feed.push_back('{1'b0, 64'h0});
  endtask

  // Issue one request, feed the queued words, then hold off out_ready for
  // 'hold' cycles before accepting the result.
  task automatic do_req(input logic [31:0] b, input logic [31:0] ev, input logic ee,
                        input logic [7:0] et, input int hold);
    int n;
    feed_t f;
    n = 0;
    while (!bus.req_ready && n < 50) begin step(); n++; end
    chk("req_ready_wait", bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_bound  = b;
    bus.rand_valid = 1'b1;   // word offered in IDLE must be discarded
    bus.rand_in    = 64'h0;
    sb.push_back('{ev, ee, et, feed.size() + 1, cyc});
    step();
    bus.req_valid = 1'b0;
    while (feed.size() > 0) begin
      f = feed.pop_front();
      bus.rand_valid = f.v;
      bus.rand_in    = f.w;
      step();
    end
    bus.rand_valid = 1'b1;   // would be accepted if the DUT were still sampling
    bus.rand_in    = 64'h0;
    n = 0;
    while (!bus.out_valid && n < 50) begin step(); n++; end
    chk("out_valid_wait", bus.out_valid, 1);
    for (int i = 0; i < hold; i++) begin
      chk("req_ready_in_done", bus.req_ready, 0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready  = 1'b0;
    bus.rand_valid = 1'b0;
    chk("req_ready_after_done", bus.req_ready, 1);
    chk("sb_drained", sb.size(), 0);
  endtask

  // Monitor: checks latency and fields on first out_valid, stability while held.
  logic        seen = 1'b0;
  logic [31:0] h_v;
  logic        h_e;
  logic [7:0]  h_t;
  always @(negedge clk) begin
    if (rst) begin
      seen = 1'b0;
    end else if (bus.out_valid) begin
      if (!seen) begin
        seen = 1'b1;
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          chk("latency", cyc - sb[0].hs, sb[0].lat);
          chk("out_value", bus.out_value, sb[0].v);
          chk("out_err", bus.out_err, sb[0].e);
          chk("out_tries", bus.out_tries, sb[0].t);
        end
        h_v = bus.out_value;
        h_e = bus.out_err;
        h_t = bus.out_tries;
      end else begin
        chk("hold_value", bus.out_value, h_v);
        chk("hold_err", bus.out_err, h_e);
        chk("hold_tries", bus.out_tries, h_t);
      end
      if (bus.out_ready) begin
        seen = 1'b0;
        if (sb.size() > 0) void'(sb.pop_front());
      end
    end
  end

  initial begin
    logic [31:0] b, m, c0, c1, ev;
    logic [63:0] w;
    logic        ee, done;
    logic [7:0]  et;

    bus.rand_in    = 64'h0;
    bus.rand_valid = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_bound  = '0;
    bus.out_ready  = 1'b0;

    // Reset state
    step(); step();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_value", bus.out_value, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_out_tries", bus.out_tries, 0);
    rst = 1'b0;
    step();
    chk("req_ready_post_rst", bus.req_ready, 1);

    // c0 rejected, c1 accepted; result held 5 cycles with out_ready low
    push_word(64'h00000007_0000000C);
    do_req(32'd10, 32'd7, 1'b0, 8'd1, 5);
    // c0 priority at bound 16
    push_word(64'h0000000F_0000001F);
    do_req(32'd16, 32'd15, 1'b0, 8'd1, 0);
    // bound 1 always gives 0
    push_word(64'hDEADBEEF_CAFEF00D);
    do_req(32'd1, 32'd0, 1'b0, 8'd1, 0);
    // bound 0: immediate error, nothing consumed
    do_req(32'd0, 32'd0, 1'b1, 8'd0, 1);
    // all words rejected: give up after MT tries
    for (int i = 0; i < MT; i++) push_word(64'h00000007_00000006);
    do_req(32'd5, 32'd0, 1'b1, 8'(MT), 0);
    // success on the last allowed try
    for (int i = 0; i < MT - 1; i++) push_word(64'h00000007_00000006);
    push_word(64'h00000007_00000004);
    do_req(32'd5, 32'd4, 1'b0, 8'(MT), 0);
    // rand_valid stalls are not counted as tries
    push_idle(3);
    push_word(64'h00000000_00000003);
    do_req(32'd8, 32'd3, 1'b0, 8'd1, 0);
    // high bits above the mask are ignored
    push_word(64'hFFFFFFF9_FFFFFFF3);
    do_req(32'd10, 32'd3, 1'b0, 8'd1, 0);
    // full-width bounds
    push_word(64'h12345678_FFFFFFFF);
    do_req(32'hFFFFFFFF, 32'h12345678, 1'b0, 8'd1, 0);
    push_word(64'h00000000_FFFFFFFF);
    do_req(32'h80000000, 32'h7FFFFFFF, 1'b0, 8'd1, 0);

    // Random requests against a reference model
    for (int r = 0; r < 12; r++) begin
      b = $urandom_range(1, 40);
      m = 0;
      while (m < b - 1) m = (m << 1) | 32'd1;
      done = 1'b0; ev = 0; ee = 1'b0; et = 0;
      for (int k = 0; k < MT && !done; k++) begin
        if ($urandom_range(0, 3) == 0) push_idle(1);
        w = {$urandom, $urandom};
        push_word(w);
        et = et + 8'd1;
        c0 = w[31:0] & m;
        c1 = w[63:32] & m;
        if (c0 < b) begin ev = c0; done = 1'b1; end
        else if (c1 < b) begin ev = c1; done = 1'b1; end
      end
      if (!done) begin ev = 0; ee = 1'b1; end
      do_req(b, ev, ee, et, $urandom_range(0, 2));
    end

    // Reset during SAMPLE abandons the request
    bus.req_valid  = 1'b1;
    bus.req_bound  = 32'd8;
    bus.rand_valid = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("sample_req_ready", bus.req_ready, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_req_ready", bus.req_ready, 0);
    step();
    rst = 1'b0;
    bus.rand_valid = 1'b1;
    bus.rand_in    = 64'h00000000_00000003;
    #1;
    chk("abandon_out_valid", bus.out_valid, 0);
    chk("abandon_req_ready", bus.req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_result_after_rst", bus.out_valid, 0);
    end
    bus.rand_valid = 1'b0;
    // Recovery
    push_word(64'h00000002_00000009);
    do_req(32'd9, 32'd2, 1'b0, 8'd1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
